// File: rtl/util_sync_filter.sv
// Multi-channel async level conditioner: flop-chain synchroniser, per-channel
// stability filter, and registered rise/fall/changed pulses.
module util_sync_filter #(
    parameter int unsigned        C_WIDTH         = 4,
    parameter int unsigned        C_NUM_STAGES    = 2,
    parameter int unsigned        C_FILTER_CYCLES = 4,
    parameter logic [C_WIDTH-1:0] C_RESET_VALUE   = {C_WIDTH{1'b0}}
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [C_WIDTH-1:0] data_in,
    output logic [C_WIDTH-1:0] data_out,
    output logic [C_WIDTH-1:0] rise,
    output logic [C_WIDTH-1:0] fall,
    output logic               changed
);

    localparam int unsigned      CNT_W    = $clog2(C_FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_FILTER_CYCLES - 1);
    localparam int unsigned      CHAIN_N  = C_NUM_STAGES - 1;

    (* ASYNC_REG = "TRUE" *)
    logic [C_WIDTH-1:0] meta_q;
    logic [C_WIDTH-1:0] meta_d;

    logic [CHAIN_N-1:0][C_WIDTH-1:0] chain_q;
    logic [CHAIN_N-1:0][C_WIDTH-1:0] chain_d;

    logic [C_WIDTH-1:0][CNT_W-1:0] cnt_q;
    logic [C_WIDTH-1:0][CNT_W-1:0] cnt_d;

    logic [C_WIDTH-1:0] data_q;
    logic [C_WIDTH-1:0] data_d;
    logic [C_WIDTH-1:0] rise_q;
    logic [C_WIDTH-1:0] rise_d;
    logic [C_WIDTH-1:0] fall_q;
    logic [C_WIDTH-1:0] fall_d;
    logic               changed_q;
    logic               changed_d;

    logic [C_WIDTH-1:0] sync;

    assign sync = chain_q[CHAIN_N-1];

    always_comb begin
        meta_d     = data_in;
        chain_d    = chain_q;
        chain_d[0] = meta_q;
        for (int k = 1; k < int'(CHAIN_N); k++) begin
            chain_d[k] = chain_q[k-1];
        end
    end

    // A channel only moves after CNT_LAST+1 consecutive mismatching samples.
    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < int'(C_WIDTH); i++) begin
            if (sync[i] == data_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                data_d[i] = sync[i];
                cnt_d[i]  = '0;
                rise_d[i] = sync[i];
                fall_d[i] = ~sync[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        changed_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q    <= C_RESET_VALUE;
            chain_q   <= {CHAIN_N{C_RESET_VALUE}};
            cnt_q     <= '0;
            data_q    <= C_RESET_VALUE;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            meta_q    <= meta_d;
            chain_q   <= chain_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end

    assign data_out = data_q;
    assign rise     = rise_q;
    assign fall     = fall_q;
    assign changed  = changed_q;

endmodule

// File: tb/tb_util_sync_filter.sv
// Bench for util_sync_filter: default instance plus a (W=1, NS=3, FC=1)
// instance, both checked every cycle against a sample-window reference.
module tb_util_sync_filter;

    localparam int HN = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] din0;
    logic [0:0] din1;
    logic [3:0] dout0, rise0, fall0;
    logic       chg0;
    logic [0:0] dout1, rise1, fall1;
    logic       chg1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    util_sync_filter u_dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (din0),
        .data_out (dout0),
        .rise     (rise0),
        .fall     (fall0),
        .changed  (chg0)
    );

    util_sync_filter #(
        .C_WIDTH         (1),
        .C_NUM_STAGES    (3),
        .C_FILTER_CYCLES (1),
        .C_RESET_VALUE   (1'b0)
    ) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (din1),
        .data_out (dout1),
        .rise     (rise1),
        .fall     (fall1),
        .changed  (chg1)
    );

    // Reference: the synchroniser is a plain delay line; a channel flips at
    // edge n when the last FC filter samples all differ from the output and
    // none of them predates the last flip or reset of that channel.
    int         ns_p [2]  = '{2, 3};
    int         fc_p [2]  = '{4, 1};
    logic [3:0] wmask [2] = '{4'hF, 4'h1};

    logic [3:0] pipe [2][4];
    logic [3:0] hist [2][HN];
    int         since [2][4];
    logic [3:0] m_out [2];
    logic [3:0] m_rise [2];
    logic [3:0] m_fall [2];
    logic       m_chg [2];
    int         edge_n = 0;
    bit         model_valid = 0;

    task automatic step(input int u, input bit rst, input logic [3:0] din);
        logic [3:0] sv;
        bit ok;
        sv = pipe[u][ns_p[u]-1];
        hist[u][edge_n % HN] = sv;
        m_rise[u] = '0;
        m_fall[u] = '0;
        if (rst) begin
            for (int k = 0; k < 4; k++) pipe[u][k] = '0;
            m_out[u] = '0;
            for (int i = 0; i < 4; i++) since[u][i] = edge_n;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[u][i]) begin
                    ok = (edge_n - fc_p[u] + 1) > since[u][i];
                    for (int j = 0; j < fc_p[u]; j++) begin
                        if (ok && hist[u][(edge_n - j) % HN][i] == m_out[u][i])
                            ok = 0;
                    end
                    if (ok) begin
                        m_out[u][i] = ~m_out[u][i];
                        if (m_out[u][i]) m_rise[u][i] = 1'b1;
                        else             m_fall[u][i] = 1'b1;
                        since[u][i] = edge_n;
                    end
                end
            end
            for (int k = 3; k > 0; k--) pipe[u][k] = pipe[u][k-1];
            pipe[u][0] = din & wmask[u];
        end
        m_chg[u] = |(m_rise[u] | m_fall[u]);
    endtask

    always @(posedge clk) begin
        step(0, !rst_n, din0);
        step(1, !rst_n, {3'b000, din1});
        if (!rst_n) model_valid = 1;
        edge_n++;
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_valid) begin
            check("m0_dout", dout0, m_out[0]);
            check("m0_rise", rise0, m_rise[0]);
            check("m0_fall", fall0, m_fall[0]);
            check("m0_chg", chg0, m_chg[0]);
            check("m0_excl", rise0 & fall0, 0);
            check("m1_dout", dout1, m_out[1][0]);
            check("m1_rise", rise1, m_rise[1][0]);
            check("m1_fall", fall1, m_fall[1][0]);
            check("m1_chg", chg1, m_chg[1]);
        end
    end

    task automatic cyc(input bit r, input logic [3:0] d0, input logic d1);
        rst_n = r;
        din0  = d0;
        din1  = d1;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] rd0;
    logic       rd1;

    initial begin
        rst_n = 1'b0;
        din0  = 4'hF;
        din1  = 1'b1;

        for (int k = 0; k < 3; k++) begin
            cyc(0, 4'hF, 1'b1);
            check("rst_dout", dout0, 4'h0);
            check("rst_pulse", rise0 | fall0, 4'h0);
        end

        for (int k = 0; k < 8; k++) begin
            cyc(1, 4'hF, 1'b1);
            if (k == 2) check("p1_dout_pre", dout1, 1'b0);
            if (k == 3) begin
                check("p1_dout", dout1, 1'b1);
                check("p1_rise", rise1, 1'b1);
            end
            if (k == 4) check("rel_dout_pre", dout0, 4'h0);
            if (k == 5) begin
                check("rel_dout", dout0, 4'hF);
                check("rel_rise", rise0, 4'hF);
                check("rel_chg", chg0, 1'b1);
            end
            if (k == 6) begin
                check("rel_rise_end", rise0, 4'h0);
                check("rel_chg_end", chg0, 1'b0);
            end
        end

        for (int k = 0; k < 20; k++) begin
            cyc(1, 4'hE, 1'b1);
            if (k == 4) check("clean_pre", dout0, 4'hF);
            if (k == 5) begin
                check("clean_dout", dout0, 4'hE);
                check("clean_fall", fall0, 4'h1);
                check("clean_rise", rise0, 4'h0);
            end
            if (k == 6) check("clean_fall_end", fall0, 4'h0);
        end

        for (int k = 0; k < 20; k++) cyc(1, 4'h0, 1'b0);

        for (int k = 0; k < 23; k++) begin
            cyc(1, (k < 3) ? 4'h2 : 4'h0, 1'b0);
            if (k == 5) check("glitch3_rise", rise0, 4'h0);
        end
        check("glitch3_dout", dout0, 4'h0);

        for (int k = 0; k < 24; k++) begin
            cyc(1, (k < 4) ? 4'h2 : 4'h0, k == 0);
            if (k == 3) check("p1_glitch_hi", dout1, 1'b1);
            if (k == 4) begin
                check("p1_glitch_lo", dout1, 1'b0);
                check("p1_glitch_fall", fall1, 1'b1);
            end
            if (k == 5) begin
                check("g4_dout", dout0, 4'h2);
                check("g4_rise", rise0, 4'h2);
            end
            if (k == 8) check("g4_hold", dout0, 4'h2);
            if (k == 9) begin
                check("g4_dout_lo", dout0, 4'h0);
                check("g4_fall", fall0, 4'h2);
            end
        end

        for (int k = 0; k < 20; k++) cyc(1, 4'h5, 1'b0);
        for (int k = 0; k < 10; k++) begin
            cyc(1, 4'hA, 1'b0);
            if (k == 5) begin
                check("sim_rise", rise0, 4'hA);
                check("sim_fall", fall0, 4'h5);
                check("sim_chg", chg0, 1'b1);
            end
            if (k == 6) begin
                check("sim_chg_end", chg0, 1'b0);
                check("sim_dout", dout0, 4'hA);
            end
        end

        for (int k = 0; k < 4; k++) cyc(1, 4'h0, 1'b0);
        cyc(0, 4'h5, 1'b0);
        check("mid_rst_dout", dout0, 4'h0);
        check("mid_rst_pulse", rise0 | fall0, 4'h0);
        check("mid_rst_chg", chg0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            cyc(1, 4'h5, 1'b0);
            if (k == 4) check("mid_pre", dout0, 4'h0);
            if (k == 5) check("mid_rise", rise0, 4'h5);
        end

        rd0 = 4'h5;
        rd1 = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 7) == 0) rd0[i] = ~rd0[i];
            if ($urandom_range(0, 3) == 0) rd1 = ~rd1;
            cyc($urandom_range(0, 199) != 0, rd0, rd1);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
